mc_controller: RTL

Multi-cycle control unit for the MIPS-subset CPU: successor to the single-cycle decoder, driving the same datapath-select codes but sequenced over FETCH/DECODE/EXEC/MEM/WB states. Sits between the instruction register (op/func), the ALU zero flag and data memory, and strobes the PC, IR, register file and memory. It adds a retired-instruction counter, illegal-opcode trapping and, optionally, a data-memory ready handshake with timeout.

---
 rtl/mc_controller.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multi-cycle control unit for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB sequencing,
// retired-instruction counter, illegal-opcode trap. Define MC_CTRL_MEMWAIT_EN for the mem_ready wait/timeout.
module mc_controller #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       reg_src,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [3:0] C_ADDU = 4'd0;
    localparam logic [3:0] C_SUBU = 4'd1;
    localparam logic [3:0] C_JR   = 4'd2;
    localparam logic [3:0] C_ORI  = 4'd3;
    localparam logic [3:0] C_LUI  = 4'd4;
    localparam logic [3:0] C_LW   = 4'd5;
    localparam logic [3:0] C_SW   = 4'd6;
    localparam logic [3:0] C_BEQ  = 4'd7;
    localparam logic [3:0] C_J    = 4'd8;
    localparam logic [3:0] C_JAL  = 4'd9;
    localparam logic [3:0] C_ILL  = 4'd10;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cls_q, cls_d, dec_cls;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_we_c, ir_we_c, mem_re_c, mem_we_c, reg_we_c;
    logic             mem_done;

    always_comb begin
        dec_cls = C_ILL;
        case (op)
            6'h00: begin
                case (func)
                    6'h21:   dec_cls = C_ADDU;
                    6'h23:   dec_cls = C_SUBU;
                    6'h08:   dec_cls = C_JR;
                    default: dec_cls = C_ILL;
                endcase
            end
            6'h0D:   dec_cls = C_ORI;
            6'h0F:   dec_cls = C_LUI;
            6'h23:   dec_cls = C_LW;
            6'h2B:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h02:   dec_cls = C_J;
            6'h03:   dec_cls = C_JAL;
            default: dec_cls = C_ILL;
        endcase
    end

`ifdef MC_CTRL_MEMWAIT_EN
    logic [7:0] wait_q, wait_d;
    logic       mem_timeout;

    assign mem_done    = mem_ready;
    assign mem_timeout = !mem_ready && (wait_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        wait_d = 8'd0;
        if (state_q == S_MEM && !mem_ready && !mem_timeout)
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= 8'd0;
        else        wait_q <= wait_d;
    end
`else
    logic mem_timeout;
    logic unused_mem_ready;

    assign mem_done         = 1'b1;
    assign mem_timeout      = 1'b0;
    assign unused_mem_ready = mem_ready;
`endif

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        pc_we_c  = 1'b0;
        ir_we_c  = 1'b0;
        mem_re_c = 1'b0;
        mem_we_c = 1'b0;
        reg_we_c = 1'b0;
        pc_src   = 2'b00;
        alu_src  = 1'b0;
        alu_op   = 2'b00;
        ext_op   = 2'b00;
        reg_dst  = 2'b00;
        reg_src  = 2'b00;
        err      = 1'b0;

        // Address/ALU controls are driven in EXEC and held through MEM.
        if (state_q == S_EXEC || state_q == S_MEM) begin
            case (cls_q)
                C_SUBU:      alu_op = 2'b01;
                C_ORI:       begin alu_op = 2'b10; alu_src = 1'b1; end
                C_LUI:       begin alu_src = 1'b1; ext_op = 2'b01; end
                C_LW, C_SW:  begin alu_src = 1'b1; ext_op = 2'b10; end
                C_BEQ:       begin alu_op = 2'b01; ext_op = 2'b10; end
                default:     ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    C_ILL: state_d = S_ERR;
                    C_J: begin
                        pc_we_c = 1'b1;
                        pc_src  = 2'b10;
                        state_d = S_FETCH;
                    end
                    C_JAL: begin
                        pc_we_c  = 1'b1;
                        pc_src   = 2'b10;
                        reg_we_c = 1'b1;
                        reg_dst  = 2'b10;
                        reg_src  = 2'b10;
                        state_d  = S_FETCH;
                    end
                    C_JR: begin
                        pc_we_c = 1'b1;
                        pc_src  = 2'b11;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_BEQ: begin
                        pc_we_c = zero;
                        pc_src  = 2'b01;
                        state_d = S_FETCH;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_re_c = (cls_q == C_LW);
                mem_we_c = (cls_q == C_SW);
                if (mem_done)         state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                else if (mem_timeout) state_d = S_ERR;
            end
            S_WB: begin
                reg_we_c = 1'b1;
                reg_dst  = (cls_q == C_ADDU || cls_q == C_SUBU) ? 2'b01 : 2'b00;
                reg_src  = (cls_q == C_LW) ? 2'b01 : 2'b00;
                state_d  = S_FETCH;
            end
            default: begin
                err     = 1'b1;
                state_d = S_ERR;
            end
        endcase
    end

    // FETCH never loops to itself and ERR never leaves, so any entry into FETCH retires one.
    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, (state_d == S_FETCH)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_ILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_we     = pc_we_c  & rst_n;
    assign ir_we     = ir_we_c  & rst_n;
    assign mem_re    = mem_re_c & rst_n;
    assign mem_we    = mem_we_c & rst_n;
    assign reg_we    = reg_we_c & rst_n;
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule
